// File: rtl/rr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb
//  Description : Round-robin arbiter with a two-state FSM. The winner is picked
//                by scanning upward from a rotation pointer. A grant is held
//                until i_done, or until a hold timeout force-releases it.
//                Every release is followed by a one-cycle idle bubble.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb #(
    parameter int N_SEL_BITS = 2,
    parameter int TIMEOUT    = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [2**N_SEL_BITS-1:0]   i_req,
    input  logic                       i_done,
    output logic                       o_gnt_valid,
    output logic [N_SEL_BITS-1:0]      o_gnt_sel,
    output logic                       o_timeout
);

    localparam int N_REQ = 2**N_SEL_BITS;

    // Last count value before a forced release (counter starts at 0 on grant).
    localparam logic [7:0] HOLD_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [N_SEL_BITS-1:0]   ptr;
    logic [N_SEL_BITS-1:0]   ptr_nxt;
    logic [7:0]              hold_cnt;
    logic [7:0]              hold_cnt_nxt;
    logic [N_SEL_BITS-1:0]   sel_nxt;
    logic                    timeout_nxt;
    logic [N_SEL_BITS-1:0]   pick;
    logic [N_SEL_BITS-1:0]   cand;
    logic                    found;

    // Winner search: first requester at or above ptr, wrapping naturally.
    always_comb begin
        pick  = ptr;
        cand  = ptr;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = ptr + k[N_SEL_BITS-1:0];
            if (!found && i_req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    // Next-state and next-output logic; outputs are registered below.
    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        hold_cnt_nxt = hold_cnt;
        sel_nxt      = o_gnt_sel;
        timeout_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    sel_nxt      = pick;
                    hold_cnt_nxt = 8'd0;
                    state_nxt    = GRANT;
                end
            end
            GRANT: begin
                if (i_done) begin
                    state_nxt = IDLE;
                    ptr_nxt   = o_gnt_sel + 1'b1;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_nxt   = IDLE;
                    ptr_nxt     = o_gnt_sel + 1'b1;
                    timeout_nxt = 1'b1;
                end else begin
                    hold_cnt_nxt = hold_cnt + 8'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, pointer, counter and output registers with asynchronous clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            hold_cnt    <= 8'd0;
            o_gnt_valid <= 1'b0;
            o_gnt_sel   <= '0;
            o_timeout   <= 1'b0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            hold_cnt    <= hold_cnt_nxt;
            o_gnt_valid <= (state_nxt == GRANT);
            o_gnt_sel   <= sel_nxt;
            o_timeout   <= timeout_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_arb
//  Description : Scoreboard bench for rr_arb (N_SEL_BITS = 2, TIMEOUT = 4).
//                A cycle-level reference model predicts the outputs after
//                each edge; a monitor compares them on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arb;

    localparam int N_SEL_BITS = 2;
    localparam int N_REQ      = 4;
    localparam int TIMEOUT    = 4;

    logic             i_clk;
    logic             i_rst_n;
    logic [N_REQ-1:0] i_req;
    logic             i_done;
    logic             o_gnt_valid;
    logic [1:0]       o_gnt_sel;
    logic             o_timeout;

    rr_arb #(
        .N_SEL_BITS (N_SEL_BITS),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_req       (i_req),
        .i_done      (i_done),
        .o_gnt_valid (o_gnt_valid),
        .o_gnt_sel   (o_gnt_sel),
        .o_timeout   (o_timeout)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic       valid;
        logic [1:0] sel;
        logic       tmo;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: who holds the grant, for how many cycles, and where
    // the next search starts.
    bit m_busy;
    int m_holder;
    int m_ptr;
    int m_held;
    bit m_tmo;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, req, $time);
    endtask

    task automatic model_reset();
        m_busy = 0; m_holder = 0; m_ptr = 0; m_held = 0; m_tmo = 0;
    endtask

    task automatic model_edge(input logic [N_REQ-1:0] req, input logic done);
        bit hit;
        m_tmo = 0;
        if (m_busy) begin
            m_held++;
            if (done) begin
                m_busy = 0;
                m_ptr  = (m_holder + 1) % N_REQ;
            end else if (m_held == TIMEOUT) begin
                m_busy = 0;
                m_ptr  = (m_holder + 1) % N_REQ;
                m_tmo  = 1;
            end
        end else if (req != '0) begin
            hit = 0;
            for (int k = 0; k < N_REQ; k++) begin
                int j;
                j = (m_ptr + k) % N_REQ;
                if (!hit && req[j]) begin
                    m_holder = j;
                    hit = 1;
                end
            end
            m_busy = 1;
            m_held = 0;
        end
    endtask

    // One clock: apply inputs, predict the post-edge outputs, queue them.
    task automatic step(input logic [N_REQ-1:0] req, input logic done);
        exp_t e;
        i_req  = req;
        i_done = done;
        @(posedge i_clk);
        model_edge(req, done);
        e.valid = m_busy;
        e.sel   = 2'(m_holder);
        e.tmo   = m_tmo;
        exp_q.push_back(e);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"},   int'(o_gnt_valid), 0);
        chk({tag, "_sel"},     int'(o_gnt_sel),   0);
        chk({tag, "_timeout"}, int'(o_timeout),   0);
    endtask

    // Reset pulsed between edges; outputs must clear with no clock edge.
    task automatic async_reset_pulse();
        #5;
        i_rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        #1;
        i_rst_n = 1'b1;
    endtask

    // Monitor: compare DUT outputs against the queued predictions.
    always @(negedge i_clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("gnt_valid", int'(o_gnt_valid), int'(e.valid));
            chk("gnt_sel",   int'(o_gnt_sel),   int'(e.sel));
            chk("timeout",   int'(o_timeout),   int'(e.tmo));
        end
    end

    initial begin
        i_rst_n = 1'b0;
        i_req   = '0;
        i_done  = 1'b0;
        model_reset();
        repeat (2) @(posedge i_clk);
        #1;
        check_reset_outputs("por");
        i_rst_n = 1'b1;

        // Idle with no requests.
        repeat (5) step(4'b0000, 1'b0);

        // All requesting, release two cycles into each grant: 0,1,2,3.
        for (int g = 0; g < 4; g++) begin
            step(4'b1111, 1'b0);
            step(4'b1111, 1'b0);
            step(4'b1111, 1'b1);
        end

        // Pointer wrapped to 0: lone requester 3, then 0 and 1 compete.
        step(4'b1000, 1'b0);
        step(4'b1000, 1'b1);
        step(4'b0011, 1'b0);
        step(4'b0011, 1'b1);

        // Grant to 1 held past the timeout, then 0 wins from ptr = 2.
        step(4'b0011, 1'b0);
        repeat (4) step(4'b0011, 1'b0);
        step(4'b0011, 1'b0);
        step(4'b0011, 1'b1);

        // Asynchronous reset in the middle of a grant to 2.
        step(4'b0100, 1'b0);
        step(4'b0100, 1'b0);
        async_reset_pulse();
        step(4'b0100, 1'b0);

        // Requester 2 drops its request while holding the grant.
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b0);

        // Done while idle must be ignored.
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);

        // Randomized traffic.
        for (int c = 0; c < 1500; c++) begin
            logic [N_REQ-1:0] r;
            logic             d;
            r = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) r = '0;
            d = ($urandom_range(0, 3) == 0);
            step(r, d);
        end

        // Let the monitor drain the queue within a bounded window.
        for (int w = 0; w < 4 && exp_q.size() > 0; w++) @(negedge i_clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
